// File: rtl/bbb_pdm_frame_packer.sv
// PDM frame packer: shifts per-microphone PDM bits into WORD_WIDTH words, double-buffers
// one completed frame and streams it one channel word per cycle over valid/ready.
module bbb_pdm_frame_packer #(
    parameter int unsigned  NUM_ROWS   = 5,
    parameter int unsigned  NUM_COLS   = 8,
    parameter int unsigned  WORD_WIDTH = 16,
    localparam int unsigned NUM_CH     = NUM_ROWS * NUM_COLS,
    localparam int unsigned CH_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               sample_valid,
    input  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  sample_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WORD_WIDTH-1:0]              out_data,
    output logic [CH_WIDTH-1:0]                out_chan,
    output logic                               out_last,
    output logic                               overflow,
    input  logic                               clear_ovf
);

    localparam int unsigned          CNT_WIDTH = $clog2(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(WORD_WIDTH - 1);
    localparam logic [CH_WIDTH-1:0]  CH_LAST   = CH_WIDTH'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_nx;
    logic [CH_WIDTH-1:0]    ch_nx;
    logic                   out_valid_nx;
    logic                   out_last_nx;
    logic [WORD_WIDTH-1:0]  out_data_nx;

    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic                   buf_full;
    logic [NUM_CH-1:0]      sample_flat;
    logic [WORD_WIDTH-1:0]  shreg     [NUM_CH];
    logic [WORD_WIDTH-1:0]  new_word  [NUM_CH];
    logic [WORD_WIDTH-1:0]  frame_buf [NUM_CH];

    logic accept;
    logic frame_done;
    logic handshake;
    logic last_hs;
    logic buf_free;
    logic load;
    logic drop;

    // Channel index is col*NUM_ROWS + row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
            assign sample_flat[c*NUM_ROWS + r] = sample_in[c][r];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_word
        assign new_word[i] = {shreg[i][WORD_WIDTH-2:0], sample_flat[i]};
    end

    assign accept     = sample_valid && enable;
    assign frame_done = accept && (bit_cnt == CNT_LAST);
    assign handshake  = out_valid && out_ready;
    assign last_hs    = handshake && out_last;
    // A buffer whose final word is being accepted this cycle counts as free
    assign buf_free   = !buf_full || last_hs;
    assign load       = frame_done && buf_free;
    assign drop       = frame_done && !buf_free;

    // Drain FSM next-state and next registered outputs
    always_comb begin
        state_nx = state_q;
        ch_nx    = out_chan;
        case (state_q)
            ST_IDLE: begin
                if (load || buf_full) begin
                    state_nx = ST_DRAIN;
                    ch_nx    = '0;
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    if (out_chan != CH_LAST) begin
                        ch_nx = out_chan + CH_WIDTH'(1);
                    end else if (load) begin
                        ch_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                        ch_nx    = '0;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                ch_nx    = '0;
            end
        endcase

        out_valid_nx = (state_nx == ST_DRAIN);
        out_last_nx  = out_valid_nx && (ch_nx == CH_LAST);
        out_data_nx  = '0;
        if (out_valid_nx) begin
            out_data_nx = load ? new_word[0] : frame_buf[ch_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            buf_full  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state_q   <= state_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            out_chan  <= ch_nx;
            out_last  <= out_last_nx;

            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end

            if (load) begin
                buf_full <= 1'b1;
            end else if (last_hs) begin
                buf_full <= 1'b0;
            end

            // Disabling discards any partial word
            if (!enable) begin
                bit_cnt <= '0;
            end else if (sample_valid) begin
                bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg     <= '{default: '0};
            frame_buf <= '{default: '0};
        end else begin
            if (accept) begin
                shreg <= new_word;
            end
            if (load) begin
                frame_buf <= new_word;
            end
        end
    end

endmodule

// File: tb/tb_bbb_pdm_frame_packer.sv
// Randomized and directed bench for bbb_pdm_frame_packer against a queue-based
// reference of the expected word stream, frame assembly and overflow flag.
module tb_bbb_pdm_frame_packer;

    localparam int NR  = 5;
    localparam int NC  = 8;
    localparam int WW  = 16;
    localparam int NCH = NR * NC;
    localparam int CHW = $clog2(NCH);

    typedef logic [NC-1:0][NR-1:0] sample_t;

    typedef struct packed {
        logic [CHW-1:0] chan;
        logic [WW-1:0]  data;
        logic           last;
    } word_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           enable;
    logic           sample_valid;
    sample_t        sample_in;
    logic           out_valid;
    logic           out_ready;
    logic [WW-1:0]  out_data;
    logic [CHW-1:0] out_chan;
    logic           out_last;
    logic           overflow;
    logic           clear_ovf;

    always #5 clk = ~clk;

    bbb_pdm_frame_packer #(
        .NUM_ROWS   (NR),
        .NUM_COLS   (NC),
        .WORD_WIDTH (WW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_last     (out_last),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    // Reference state: words still owed to the consumer, samples since last word boundary
    word_t      exp_q[$];
    sample_t    hist[$];
    bit         m_ovf;
    logic [WW-1:0] got_word [NCH];
    int         n_cmp;
    int         n_err;
    int         idle_cnt;
    int         last_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic sample_t rand_sample();
        return sample_t'({$urandom(), $urandom()});
    endfunction

    // Frame word for a channel: oldest sample is the MSB
    function automatic void build_frame();
        for (int col = 0; col < NC; col++) begin
            for (int row = 0; row < NR; row++) begin
                word_t w;
                sample_t s;
                w.data = '0;
                for (int k = 0; k < WW; k++) begin
                    s = hist[k];
                    w.data = {w.data[WW-2:0], s[col][row]};
                end
                w.chan = CHW'(col * NR + row);
                w.last = (col * NR + row == NCH - 1);
                exp_q.push_back(w);
            end
        end
    endfunction

    // Compare current outputs, drive one cycle of inputs, advance the reference
    task automatic step(input logic sv, input sample_t sin, input logic rdy,
                        input logic en, input logic clr, input logic rst_n);
        bit drop;
        check("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_chan", out_chan, exp_q[0].chan);
            check("out_last", out_last, exp_q[0].last);
        end
        check("overflow", overflow, m_ovf);
        if (out_valid !== 1'b1) idle_cnt++;

        reset_n      = rst_n;
        enable       = en;
        sample_valid = sv;
        sample_in    = sin;
        out_ready    = rdy;
        clear_ovf    = clr;

        if (!rst_n) begin
            exp_q.delete();
            hist.delete();
            m_ovf = 1'b0;
        end else begin
            drop = 1'b0;
            if (exp_q.size() > 0 && rdy) begin
                got_word[exp_q[0].chan] = out_data;
                if (exp_q[0].last) last_cnt++;
                void'(exp_q.pop_front());
            end
            if (!en) begin
                hist.delete();
            end else if (sv) begin
                hist.push_back(sin);
                if (hist.size() == WW) begin
                    if (exp_q.size() == 0) build_frame();
                    else drop = 1'b1;
                    hist.delete();
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic strobes(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, rand_sample(), rdy, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        sample_t s;
        logic [WW-1:0] held;
        int base;
        bit found;

        n_cmp = 0;
        n_err = 0;
        idle_cnt = 0;
        last_cnt = 0;
        m_ovf = 1'b0;
        reset_n = 1'b0;
        enable = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_chan", out_chan, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", overflow, 0);

        // Single 1 on channel 0 in the first sample
        base = last_cnt;
        for (int i = 0; i < WW; i++) begin
            s = '0;
            if (i == 0) s[0][0] = 1'b1;
            step(1'b1, s, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        quiet(45, 1'b1);
        check("ch0_word", got_word[0], 16'h8000);
        check("ch39_word", got_word[NCH-1], 16'h0000);
        check("ch0_frames", last_cnt - base, 1);

        // Constant 1 at col 2 row 3 and output latency
        s = '0;
        s[2][3] = 1'b1;
        for (int i = 0; i < WW - 1; i++) step(1'b1, s, 1'b1, 1'b1, 1'b0, 1'b1);
        check("pre_valid", out_valid, 0);
        step(1'b1, s, 1'b1, 1'b1, 1'b0, 1'b1);
        check("lat_valid", out_valid, 1);
        check("lat_chan", out_chan, 0);
        quiet(45, 1'b1);
        check("ch13_word", got_word[13], 16'hFFFF);
        check("ch12_word", got_word[12], 16'h0000);

        // Next frame completes on the same edge as the last-word handshake
        strobes(WW, 1'b1);
        idle_cnt = 0;
        for (int k = 1; k <= 2 * NCH; k++) begin
            step(k >= NCH - WW + 1 && k <= NCH, rand_sample(), 1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("b2b_gap", idle_cnt, 0);
        check("b2b_ovf", overflow, 0);
        quiet(5, 1'b1);

        // Partial word discarded by enable low
        base = last_cnt;
        strobes(7, 1'b1);
        step(1'b1, rand_sample(), 1'b1, 1'b0, 1'b0, 1'b1);
        strobes(WW, 1'b1);
        quiet(45, 1'b1);
        check("en_frames", last_cnt - base, 1);

        // Backpressure: hold first frame, drop the next two
        strobes(WW, 1'b0);
        held = out_data;
        strobes(2 * WW, 1'b0);
        check("bp_hold", out_data, held);
        check("bp_ovf", overflow, 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("bp_clear", overflow, 0);
        quiet(45, 1'b1);

        // Randomized traffic at several densities
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 700; i++) begin
                step($urandom_range(0, 3) <= ph,
                     rand_sample(),
                     $urandom_range(0, 9) < 4 + 3 * ph,
                     $urandom_range(0, 99) < 97,
                     $urandom_range(0, 99) < 2,
                     1'b1);
            end
        end

        // Synchronous reset mid-drain
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (out_valid === 1'b1 && out_chan === CHW'(20)) found = 1'b1;
            else step(1'b1, rand_sample(), 1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("rst_wait", found, 1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_chan", out_chan, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_ovf", overflow, 0);
        strobes(WW - 1, 1'b1);
        check("post_rst_idle", out_valid, 0);
        strobes(1, 1'b1);
        check("post_rst_valid", out_valid, 1);
        quiet(45, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bbb_pdm_frame_packer.md
# bbb_pdm_frame_packer

Downstream stage of the microphone-array adapter. It collects the registered per-microphone PDM bits (NUM_COLS × NUM_ROWS channels), shift-packs WORD_WIDTH consecutive bits per channel into words, and streams one frame of words per channel over a valid/ready interface. Its output feeds the DMA/FIFO bridge to the host. It double-buffers one frame and flags frames dropped under backpressure.

## Interface
Parameters:
- NUM_ROWS, 5, microphone rows (bits per column).
- NUM_COLS, 8, microphone columns.
- WORD_WIDTH, 16, PDM bits packed per output word (≥2).
- NUM_CH, NUM_ROWS*NUM_COLS, derived channel count.
- CH_WIDTH, $clog2(NUM_CH), derived channel index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  packing enable.
- sample_valid  in  1  single-cycle strobe; sample_in holds a complete, stable array sample.
- sample_in  in  [NUM_COLS-1:0][NUM_ROWS-1:0]  PDM bits, indexed [col][row].
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  WORD_WIDTH  packed word.
- out_chan  out  CH_WIDTH  channel index = col*NUM_ROWS + row.
- out_last  out  1  high on the channel NUM_CH-1 word of a frame.
- overflow  out  1  sticky: a completed frame was dropped.
- clear_ovf  in  1  clears overflow.

## Operation
- Per channel, a WORD_WIDTH shift register: on sample_valid && enable, shreg <= {shreg[WORD_WIDTH-2:0], bit}. The first bit received ends in the MSB.
- bit_cnt counts accepted samples from 0 to WORD_WIDTH-1. On the sample that completes a word (bit_cnt == WORD_WIDTH-1), bit_cnt wraps to 0 and all completed words (including that sample) form a frame.
- Completed frame:
  - If the frame buffer is free, it is copied into the buffer and buf_full is set.
  - Otherwise the frame is discarded and overflow is set.
  - The shift registers keep running either way; there is no stall.
- Drain FSM:
  - IDLE: out_valid=0. On buf_full, go to DRAIN with ch=0.
  - DRAIN: out_valid=1, out_data=buf[ch], out_chan=ch, out_last=(ch==NUM_CH-1). On out_valid && out_ready: if ch<NUM_CH-1 then ch++; else clear buf_full and go to IDLE.
- Simultaneous events:
  - If a frame completes in the same cycle the out_last word is accepted, the buffer counts as free. The new frame is loaded, no overflow is raised, and the FSM re-enters DRAIN with no idle gap.
  - If clear_ovf and a new drop occur in the same cycle, overflow stays 1.
- enable low: sample_valid is ignored and bit_cnt is forced to 0, so a partial word is discarded. Any buffered frame still drains normally.
- Reset: out_valid=0, out_data=0, out_chan=0, out_last=0, overflow=0, bit_cnt=0, buf_full=0, all shift registers and the buffer are 0, FSM=IDLE.

## Timing
- Frame load occurs at the clock edge that samples the completing sample_valid. out_valid rises the next cycle (1-cycle latency).
- Outputs are registered. out_data, out_chan and out_last stay stable while out_valid && !out_ready. out_valid never drops without a handshake, except on reset.
- With out_ready held high, a frame drains in exactly NUM_CH cycles (40 by default), one word per cycle.
- No drops occur if the drain finishes within WORD_WIDTH sample_valid periods.
- A synchronous reset mid-drain aborts the frame. Outputs are at reset values on the cycle after reset_n is sampled low.

## Test plan
- Reset, then enable. Drive 16 sample_valid strobes with channel 0 pattern 1,0,0,…,0 and all other channels 0, out_ready=1 → 40 words, ch0 = 0x8000, others 0x0000, out_last only on out_chan=39, overflow=0.
- Drive sample_in[col][row]=1 for a constant sample at col=2, row=3 → word on out_chan=13 = 0xFFFF. Check word order 0..39 and out_valid rising exactly 1 cycle after the 16th strobe.
- Hold out_ready=0 for 2 full frame periods → first frame is held stable with out_data unchanged, second frame is dropped, overflow=1. Pulse clear_ovf → overflow=0, and the first frame then drains intact.
- Time the 16th strobe of frame N+1 to the same cycle as the frame N out_last handshake → no overflow, back-to-back frames with no idle cycle between words 39 and 0.
- Deassert enable after 7 strobes, reassert, then send 16 strobes → exactly one frame, built from the last 16 samples only.
- Assert reset_n=0 mid-drain at ch=20 → next cycle out_valid=0 and all outputs zero. After release, the first frame appears only after 16 new strobes.
